// File: rtl/dec_pkg.sv
// Shared types and constants for the BCD digit entry path.
package dec_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam int unsigned BOARD_MAX_IDX = 81;
   localparam int unsigned BCD_MAX       = 9;

endpackage

// File: rtl/bcd2_to_bin.sv
// Two BCD digits to binary (tens*10+ones via shifts), plus a legality check on one digit.
module bcd2_to_bin
   import dec_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [3:0]       tens_i,
   input  logic [3:0]       ones_i,
   input  logic [3:0]       chk_i,
   output logic [WIDTH-1:0] value_o,
   output logic             legal_o
);

   assign value_o = (WIDTH'(tens_i) << 3) + (WIDTH'(tens_i) << 1) + WIDTH'(ones_i);
   assign legal_o = (chk_i <= 4'(BCD_MAX));

endmodule

// File: rtl/dec_to_byte.sv
// Collects up to two BCD digits, commits them as a range-checked byte over valid/ready,
// and echoes the partial entry for the display.
module dec_to_byte
   import dec_pkg::*;
#(
   parameter int unsigned MAX_VAL = BOARD_MAX_IDX,
   parameter int unsigned WIDTH   = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [3:0]       digit_in,
   input  logic             digit_valid_in,
   output logic             digit_ready_out,
   input  logic             enter_in,
   input  logic             clear_in,
   output logic [WIDTH-1:0] byte_out,
   output logic             byte_valid_out,
   input  logic             byte_ready_in,
   output logic             err_out,
   output logic [3:0]       entry_tens_out,
   output logic [3:0]       entry_ones_out,
   output logic [1:0]       entry_count_out
);

   state_t           state_q, state_d;
   bcd_t             tens_q, tens_d, ones_q, ones_d;
   bcd_t             tens_n, ones_n;
   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] byte_q, byte_d;
   logic             err_q, err_d;

   logic             digit_rdy;
   logic             digit_acc;
   logic             digit_legal;
   logic             dig_take;
   logic             commit_req;
   logic             in_range;
   logic [WIDTH-1:0] value;

   assign digit_rdy  = (state_q == S_EMPTY) || (state_q == S_ONE);
   assign digit_acc  = digit_valid_in && digit_rdy;
   assign in_range   = (value <= WIDTH'(MAX_VAL));
   assign commit_req = enter_in && !clear_in && (state_q != S_HOLD) &&
                       ((state_q != S_EMPTY) || dig_take);

   // Digit set as it stands after any digit taken this cycle; enter sees this view.
   always_comb begin
      tens_n   = tens_q;
      ones_n   = ones_q;
      dig_take = 1'b0;
      if (digit_acc && digit_legal && !clear_in) begin
         dig_take = 1'b1;
         tens_n   = (state_q == S_ONE) ? ones_q : bcd_t'(0);
         ones_n   = digit_in;
      end
   end

   bcd2_to_bin #(
      .WIDTH (WIDTH)
   ) u_conv (
      .tens_i  (tens_n),
      .ones_i  (ones_n),
      .chk_i   (digit_in),
      .value_o (value),
      .legal_o (digit_legal)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= S_EMPTY;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_in) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY, S_ONE, S_TWO: begin
               if (commit_req)    state_d = in_range ? S_HOLD : S_EMPTY;
               else if (dig_take) state_d = (state_q == S_EMPTY) ? S_ONE : S_TWO;
            end
            S_HOLD: begin
               if (byte_ready_in) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Datapath next values: echoes, committed byte and error pulse.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      cnt_d  = cnt_q;
      byte_d = byte_q;
      err_d  = 1'b0;
      if (clear_in) begin
         tens_d = '0;
         ones_d = '0;
         cnt_d  = '0;
      end else begin
         if (digit_acc && !digit_legal) err_d = 1'b1;
         if (dig_take) begin
            tens_d = tens_n;
            ones_d = ones_n;
            cnt_d  = cnt_q + 2'd1;
         end
         if (commit_req) begin
            if (in_range) begin
               byte_d = value;
            end else begin
               err_d  = 1'b1;
               tens_d = '0;
               ones_d = '0;
               cnt_d  = '0;
            end
         end
         if ((state_q == S_HOLD) && byte_ready_in) begin
            tens_d = '0;
            ones_d = '0;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tens_q <= '0;
         ones_q <= '0;
         cnt_q  <= '0;
         byte_q <= '0;
         err_q  <= 1'b0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
         cnt_q  <= cnt_d;
         byte_q <= byte_d;
         err_q  <= err_d;
      end
   end

   assign digit_ready_out = digit_rdy;
   assign byte_out        = byte_q;
   assign byte_valid_out  = (state_q == S_HOLD);
   assign err_out         = err_q;
   assign entry_tens_out  = tens_q;
   assign entry_ones_out  = ones_q;
   assign entry_count_out = cnt_q;

endmodule

// File: tb/tb_dec_to_byte.sv
// Directed bench for dec_to_byte with a queue of expected committed bytes.
module tb_dec_to_byte;

   logic       clk_in = 1'b0;
   logic       rst_n_in = 1'b0;
   logic [3:0] digit_in = '0;
   logic       digit_valid_in = 1'b0;
   logic       digit_ready_out;
   logic       enter_in = 1'b0;
   logic       clear_in = 1'b0;
   logic [7:0] byte_out;
   logic       byte_valid_out;
   logic       byte_ready_in = 1'b0;
   logic       err_out;
   logic [3:0] entry_tens_out;
   logic [3:0] entry_ones_out;
   logic [1:0] entry_count_out;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];

   dec_to_byte dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .digit_in        (digit_in),
      .digit_valid_in  (digit_valid_in),
      .digit_ready_out (digit_ready_out),
      .enter_in        (enter_in),
      .clear_in        (clear_in),
      .byte_out        (byte_out),
      .byte_valid_out  (byte_valid_out),
      .byte_ready_in   (byte_ready_in),
      .err_out         (err_out),
      .entry_tens_out  (entry_tens_out),
      .entry_ones_out  (entry_ones_out),
      .entry_count_out (entry_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling happens 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_digit(input logic [3:0] d);
      digit_in       = d;
      digit_valid_in = 1'b1;
      tick();
      digit_valid_in = 1'b0;
   endtask

   task automatic do_enter();
      enter_in = 1'b1;
      tick();
      enter_in = 1'b0;
   endtask

   // Consume the held byte and score it against the oldest expected commit.
   task automatic handshake(input string tag);
      int e;
      byte_ready_in = 1'b1;
      chk({tag, "_valid"}, 32'(byte_valid_out), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_byte"}, 32'(byte_out), 32'(e));
      end
      tick();
      byte_ready_in = 1'b0;
      chk({tag, "_drop"}, 32'(byte_valid_out), 32'd0);
      chk({tag, "_cnt0"}, 32'(entry_count_out), 32'd0);
   endtask

   initial begin
      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         digit_in       = 4'($urandom_range(0, 15));
         digit_valid_in = 1'($urandom);
         enter_in       = 1'($urandom);
         clear_in       = 1'($urandom);
         byte_ready_in  = 1'($urandom);
         tick();
         chk("rst_byte", 32'(byte_out), 32'd0);
         chk("rst_valid", 32'(byte_valid_out), 32'd0);
         chk("rst_err", 32'(err_out), 32'd0);
         chk("rst_echo", 32'({entry_tens_out, entry_ones_out, entry_count_out}), 32'd0);
         chk("rst_ready", 32'(digit_ready_out), 32'd1);
      end
      digit_valid_in = 1'b0;
      enter_in       = 1'b0;
      clear_in       = 1'b0;
      byte_ready_in  = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();

      // 4, 2, enter -> 42 held under backpressure
      send_digit(4'd4);
      chk("d4_cnt", 32'(entry_count_out), 32'd1);
      send_digit(4'd2);
      chk("d42_tens", 32'(entry_tens_out), 32'd4);
      chk("d42_ones", 32'(entry_ones_out), 32'd2);
      chk("d42_cnt", 32'(entry_count_out), 32'd2);
      exp_q.push_back(42);
      do_enter();
      chk("e42_valid", 32'(byte_valid_out), 32'd1);
      chk("e42_ready", 32'(digit_ready_out), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold42_byte", 32'(byte_out), 32'd42);
         chk("hold42_valid", 32'(byte_valid_out), 32'd1);
      end
      handshake("hs42");
      chk("post42_byte", 32'(byte_out), 32'd42);

      // Range limit
      send_digit(4'd8);
      send_digit(4'd1);
      exp_q.push_back(81);
      do_enter();
      handshake("hs81");
      send_digit(4'd8);
      send_digit(4'd2);
      do_enter();
      chk("e82_err", 32'(err_out), 32'd1);
      chk("e82_valid", 32'(byte_valid_out), 32'd0);
      chk("e82_cnt", 32'(entry_count_out), 32'd0);
      chk("e82_ready", 32'(digit_ready_out), 32'd1);
      chk("e82_byte", 32'(byte_out), 32'd81);
      tick();
      chk("e82_err_once", 32'(err_out), 32'd0);

      // Same-cycle digit + enter
      digit_in = 4'd9; digit_valid_in = 1'b1;
      exp_q.push_back(9);
      do_enter();
      digit_valid_in = 1'b0;
      handshake("hs9");
      send_digit(4'd3);
      digit_in = 4'd5; digit_valid_in = 1'b1;
      exp_q.push_back(35);
      do_enter();
      digit_valid_in = 1'b0;
      handshake("hs35");

      // Digit + clear
      send_digit(4'd7);
      digit_in = 4'd6; digit_valid_in = 1'b1; clear_in = 1'b1;
      tick();
      digit_valid_in = 1'b0; clear_in = 1'b0;
      chk("clr_cnt", 32'(entry_count_out), 32'd0);
      chk("clr_valid", 32'(byte_valid_out), 32'd0);
      chk("clr_err", 32'(err_out), 32'd0);

      // Illegal digits, back-to-back
      send_digit(4'd5);
      digit_in = 4'd12; digit_valid_in = 1'b1;
      tick();
      chk("ill1_err", 32'(err_out), 32'd1);
      chk("ill1_cnt", 32'(entry_count_out), 32'd1);
      chk("ill1_ones", 32'(entry_ones_out), 32'd5);
      digit_in = 4'd13;
      tick();
      digit_valid_in = 1'b0;
      chk("ill2_err", 32'(err_out), 32'd1);
      tick();
      chk("ill_err_end", 32'(err_out), 32'd0);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;

      // Third digit blocked in S_TWO
      send_digit(4'd1);
      send_digit(4'd2);
      digit_in = 4'd3; digit_valid_in = 1'b1;
      chk("s2_ready", 32'(digit_ready_out), 32'd0);
      tick();
      digit_valid_in = 1'b0;
      chk("s2_tens", 32'(entry_tens_out), 32'd1);
      chk("s2_ones", 32'(entry_ones_out), 32'd2);
      chk("s2_cnt", 32'(entry_count_out), 32'd2);
      exp_q.push_back(12);
      do_enter();
      handshake("hs12");

      // Leading zeros
      send_digit(4'd0);
      send_digit(4'd7);
      exp_q.push_back(7);
      do_enter();
      handshake("hs07");
      send_digit(4'd0);
      send_digit(4'd0);
      exp_q.push_back(0);
      do_enter();
      handshake("hs00");

      // Clear while holding 50
      send_digit(4'd5);
      send_digit(4'd0);
      do_enter();
      chk("h50_valid", 32'(byte_valid_out), 32'd1);
      chk("h50_byte", 32'(byte_out), 32'd50);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      chk("c50_valid", 32'(byte_valid_out), 32'd0);
      chk("c50_cnt", 32'(entry_count_out), 32'd0);
      byte_ready_in = 1'b1;
      tick();
      byte_ready_in = 1'b0;
      chk("c50_nohs", 32'(byte_valid_out), 32'd0);

      // Asynchronous reset mid-entry
      send_digit(4'd6);
      chk("m6_ones", 32'(entry_ones_out), 32'd6);
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("arst_cnt", 32'(entry_count_out), 32'd0);
      chk("arst_ones", 32'(entry_ones_out), 32'd0);
      chk("arst_byte", 32'(byte_out), 32'd0);
      chk("arst_ready", 32'(digit_ready_out), 32'd1);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();
      chk("arst_after", 32'(entry_count_out), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dec_to_byte.md
Name: dec_to_byte

Overview:
Assembles a 0..MAX_VAL board index from a stream of BCD digits entered one at a time, such as keypad or UART-parsed digits.
Delivers the index as a byte over a valid/ready handshake to the game-logic consumer.
It is the inverse of the existing byte-to-two-decimal-digit display path.
It also echoes the partially entered digits so the display can show them while entry is in progress.

Parameters:
MAX_VAL, 81, largest legal committed value (inclusive); values above it are rejected with err_out.
WIDTH, 8, width of byte_out; must be >= 7 so that 99 fits.

Ports:
clk_in  input  1  system clock; all state changes on rising edge.
rst_n_in  input  1  asynchronous, active-low reset.
digit_in  input  4  BCD digit, legal range 0..9.
digit_valid_in  input  1  digit_in is valid this cycle.
digit_ready_out  output  1  a digit can be accepted this cycle.
enter_in  input  1  commit the current entry (single-cycle strobe).
clear_in  input  1  abandon the entry and any held output.
byte_out  output  WIDTH  committed value; stable while byte_valid_out is high.
byte_valid_out  output  1  byte_out holds a committed value.
byte_ready_in  input  1  consumer accepts byte_out.
err_out  output  1  one-cycle pulse on a rejected digit or a rejected commit.
entry_tens_out  output  4  echo of the tens digit entered so far (0 if none).
entry_ones_out  output  4  echo of the ones digit entered so far (0 if none).
entry_count_out  output  2  number of digits held: 0, 1 or 2.

Behaviour:
- Reset (async, rst_n_in=0): state S_EMPTY; byte_out=0; byte_valid_out=0; err_out=0; entry_tens_out=0; entry_ones_out=0; entry_count_out=0. Reset mid-entry or mid-handshake discards everything.
- Ready and accept rules:
  - digit_ready_out=1 exactly in S_EMPTY and S_ONE. It is a function of state only.
  - A digit is accepted when digit_valid_in && digit_ready_out.
- States:
  - S_EMPTY + accepted digit -> S_ONE; ones=d, tens=0.
  - S_ONE + accepted digit -> S_TWO; tens=old ones, ones=d (digits shift left).
  - S_TWO: digits are not accepted. A third digit must wait for clear_in or enter_in.
  - S_HOLD: byte_valid_out=1. On byte_valid_out && byte_ready_in -> S_EMPTY next cycle, with byte_valid_out=0 and all echoes cleared.
- Illegal digit: an accepted digit with value >9 is dropped, state is unchanged, and err_out pulses on the next cycle.
- enter_in:
  - In S_EMPTY with no digit that cycle: ignored.
  - Otherwise the value is computed as tens*10+ones, using the digit set after any digit accepted in the same cycle.
  - Example: S_ONE holding 3, plus digit 5 and enter in the same cycle, commits 35. S_EMPTY plus digit 7 and enter in the same cycle commits 7.
  - If value <= MAX_VAL: go to S_HOLD; byte_out=value and byte_valid_out=1 one cycle after enter (latency 1).
  - If value > MAX_VAL: go to S_EMPTY and err_out pulses for one cycle; byte_out is unchanged.
  - enter_in in S_HOLD is ignored.
- clear_in: highest priority. In any state the next state is S_EMPTY, echoes are cleared and byte_valid_out=0, including when a held value has not been accepted. In a cycle with clear_in, digits and enter_in are ignored, but digit_ready_out still reflects state, so the digit is consumed and discarded.
- Arithmetic: tens*10 = (tens<<3)+(tens<<1), zero-extended to WIDTH; maximum 99, no overflow.
- Leading zero: 0 then 7 commits 7; 0 then 0 commits 0.
- byte_out retains the last committed value after the handshake; consumers qualify it with byte_valid_out.
- err_out is registered, one cycle wide; back-to-back errors produce back-to-back pulses.

Decomposition:
- Package dec_pkg:
  - State enum: S_EMPTY, S_ONE, S_TWO, S_HOLD.
  - typedef bcd_t (logic [3:0]).
  - Constant BOARD_MAX_IDX=81, used as the MAX_VAL default.
- Sub-module bcd2_to_bin: combinational tens/ones to WIDTH-bit value, plus a digit-legal flag.

Test Plan:
- Reset: hold rst_n_in low with random inputs -> all outputs 0, digit_ready_out=1. Release reset, enter digits 4 and 2, pulse enter -> byte_out=42, byte_valid_out=1 one cycle later. Hold byte_ready_in=0 for 5 cycles -> output stable. Raise ready -> byte_valid_out=0 next cycle, entry_count_out=0.
- Range limit: enter 8,1 then enter -> 81 accepted. Enter 8,2 then enter -> err_out pulses once, byte_valid_out stays 0, state returns to S_EMPTY.
- Same-cycle events:
  - Digit 9 plus enter in S_EMPTY -> byte_out=9.
  - Digit 5 plus enter in S_ONE holding 3 -> byte_out=35.
  - Digit plus clear -> entry_count_out=0, no output.
- Illegal digit and third digit: digit 12 -> err_out pulse, entry_count_out unchanged. In S_TWO (digits 1,2) drive digit 3 valid -> digit_ready_out=0, echoes stay 1/2; enter -> 12.
- Clear during hold: commit 50 with byte_ready_in=0, then pulse clear_in -> byte_valid_out=0 next cycle, no handshake occurs. Assert rst_n_in low mid-entry (digit 6 held) -> outputs 0 immediately, without waiting for a clock edge.
